// File: rtl/wb_ips_splitter_if.sv
// Wishbone bundle for the caravel_ips splitter: upstream slave port from the
// management SoC plus the shared/one-hot downstream bus towards the IP slaves.
interface wb_ips_splitter_if #(
    parameter int NS = 4
);
    logic            wbs_cyc_i;
    logic            wbs_stb_i;
    logic            wbs_we_i;
    logic [3:0]      wbs_sel_i;
    logic [31:0]     wbs_adr_i;
    logic [31:0]     wbs_dat_i;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;
    logic [NS-1:0]   m_cyc_o;
    logic [NS-1:0]   m_stb_o;
    logic            m_we_o;
    logic [3:0]      m_sel_o;
    logic [31:0]     m_adr_o;
    logic [31:0]     m_dat_o;
    logic [NS*32-1:0] m_dat_i;
    logic [NS-1:0]   m_ack_i;
    logic            timeout_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  m_dat_i, m_ack_i,
        output wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
        output m_adr_o, m_dat_o, timeout_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output m_dat_i, m_ack_i,
        input  wbs_ack_o, wbs_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
        input  m_adr_o, m_dat_o, timeout_o
    );
endinterface

// File: rtl/wb_ips_splitter.sv
// Wishbone 1:NS address splitter; decode misses and hung slaves are answered
// with ERR_DATA so the management SoC never stalls.
module wb_ips_splitter #(
    parameter int          NS       = 4,
    parameter int          SLOT_AW  = 16,
    parameter logic [31:0] BASE     = 32'h3000_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_ips_splitter_if.slave   bus
);
    localparam int SW = $clog2(NS);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   slot_q;
    logic [CW-1:0]   cnt_q;
    logic [NS-1:0]   sel_onehot_q;
    logic            ack_q;
    logic [31:0]     rdat_q;
    logic            timeout_q;
    logic            we_q;
    logic [3:0]      bsel_q;
    logic [31:0]     adr_q;
    logic [31:0]     wdat_q;

    logic [SW-1:0]   dec_slot;
    logic            dec_hit;

    // A slot index past NS is only possible when NS is not a power of two.
    assign dec_slot = bus.wbs_adr_i[SLOT_AW+SW-1:SLOT_AW];
    assign dec_hit  = (bus.wbs_adr_i[31:SLOT_AW+SW] == BASE[31:SLOT_AW+SW]) &&
                      ({{(32-SW){1'b0}}, dec_slot} < 32'(NS));

    // Request/response FSM; every bus output is a register of this block.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            cnt_q        <= '0;
            sel_onehot_q <= '0;
            ack_q        <= 1'b0;
            rdat_q       <= 32'h0000_0000;
            timeout_q    <= 1'b0;
            we_q         <= 1'b0;
            bsel_q       <= 4'b0000;
            adr_q        <= 32'h0000_0000;
            wdat_q       <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q     <= 1'b0;
                    timeout_q <= 1'b0;
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        if (dec_hit) begin
                            we_q         <= bus.wbs_we_i;
                            bsel_q       <= bus.wbs_sel_i;
                            adr_q        <= bus.wbs_adr_i;
                            wdat_q       <= bus.wbs_dat_i;
                            slot_q       <= dec_slot;
                            sel_onehot_q <= {{(NS-1){1'b0}}, 1'b1} << dec_slot;
                            cnt_q        <= '0;
                            state_q      <= BUSY;
                        end else begin
                            rdat_q  <= ERR_DATA;
                            ack_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // Master abort wins over a coincident slave ack.
                    if (!bus.wbs_cyc_i) begin
                        sel_onehot_q <= '0;
                        state_q      <= IDLE;
                    end else if (bus.m_ack_i[slot_q]) begin
                        rdat_q       <= bus.m_dat_i[32*slot_q +: 32];
                        sel_onehot_q <= '0;
                        ack_q        <= 1'b1;
                        state_q      <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rdat_q       <= ERR_DATA;
                        sel_onehot_q <= '0;
                        ack_q        <= 1'b1;
                        timeout_q    <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    ack_q     <= 1'b0;
                    timeout_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    sel_onehot_q <= '0;
                    ack_q        <= 1'b0;
                    timeout_q    <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdat_q;
    assign bus.m_cyc_o   = sel_onehot_q;
    assign bus.m_stb_o   = sel_onehot_q;
    assign bus.m_we_o    = we_q;
    assign bus.m_sel_o   = bsel_q;
    assign bus.m_adr_o   = adr_q;
    assign bus.m_dat_o   = wdat_q;
    assign bus.timeout_o = timeout_q;
endmodule

// File: tb/tb_wb_ips_splitter.sv
// Bench for wb_ips_splitter: directed vector table, reset/abort sequences and
// randomized transfers checked against a transaction-level expectation model.
module tb_wb_ips_splitter;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          ack_k;      // edge at which the slave acks, 0 = never
        logic [3:0]  foreign;    // acks raised by other slots (must be ignored)
        logic [31:0] sdat;       // read data offered by the addressed slot
        int          exp_edge;   // edge at which the master samples wbs_ack_o
        logic [31:0] exp_dat;
        int          exp_to;
        int          exp_stb;    // cycles the slot strobe is visible
        logic [3:0]  exp_onehot;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    wb_ips_splitter_if #(.NS(4)) bus ();

    wb_ips_splitter dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: address decode, then ack edge from slave latency.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   slot;
        r    = v;
        slot = int'((v.adr >> 16) & 32'd3);
        if ((v.adr >> 18) != (32'h3000_0000 >> 18)) begin
            r.exp_edge = 1; r.exp_dat = ERR; r.exp_to = 0; r.exp_stb = 0; r.exp_onehot = 4'b0000;
        end else if (v.ack_k >= 1 && v.ack_k <= 255) begin
            r.exp_edge = v.ack_k + 1; r.exp_dat = v.sdat; r.exp_to = 0;
            r.exp_stb = v.ack_k; r.exp_onehot = 4'(1 << slot);
        end else begin
            r.exp_edge = 256; r.exp_dat = ERR; r.exp_to = 1;
            r.exp_stb = 255; r.exp_onehot = 4'(1 << slot);
        end
        return r;
    endfunction

    task automatic idle_inputs();
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'b0000; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        bus.m_ack_i = 4'b0000; bus.m_dat_i = 128'h0;
    endtask

    task automatic do_vec(input string name, input vec_t v);
        int          slot, ack_edge, to_cnt, stb_cnt, bad_cnt;
        logic [3:0]  own, stb_seen;
        logic [31:0] rdat;
        logic        c_we;
        logic [3:0]  c_sel;
        logic [31:0] c_adr, c_dat;
        slot = int'(v.adr[17:16]);
        own  = 4'(1 << slot);
        ack_edge = 0; to_cnt = 0; stb_cnt = 0; bad_cnt = 0; stb_seen = 4'b0000; rdat = 32'h0;
        c_we = 1'b0; c_sel = 4'b0000; c_adr = 32'h0; c_dat = 32'h0;
        for (int s = 0; s < 4; s++) bus.m_dat_i[32*s +: 32] = $urandom;
        bus.m_dat_i[32*slot +: 32] = v.sdat;
        bus.wbs_adr_i = v.adr; bus.wbs_we_i = v.we; bus.wbs_sel_i = v.sel; bus.wbs_dat_i = v.wdat;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.m_ack_i = v.foreign & ~own;
        @(posedge clk); #1;
        for (int k = 1; k <= 300; k++) begin
            if (bus.timeout_o) to_cnt++;
            if (bus.wbs_ack_o) begin
                ack_edge = k; rdat = bus.wbs_dat_o;
                bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.m_ack_i = 4'b0000;
                break;
            end
            if (bus.m_stb_o != 4'b0000) begin stb_cnt++; stb_seen = stb_seen | bus.m_stb_o; end
            if (bus.m_stb_o != bus.m_cyc_o || $countones(bus.m_stb_o) > 1) bad_cnt++;
            if (k == 1) begin c_we = bus.m_we_o; c_sel = bus.m_sel_o; c_adr = bus.m_adr_o; c_dat = bus.m_dat_o; end
            bus.m_ack_i = ((k == v.ack_k) ? own : 4'b0000) | (v.foreign & ~own);
            @(posedge clk); #1;
        end
        if (ack_edge == 0) begin
            bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.m_ack_i = 4'b0000;
        end
        @(posedge clk); #1;
        if (bus.wbs_ack_o || bus.timeout_o || bus.m_stb_o != 4'b0000) bad_cnt++;
        chk({name, ".ack_edge"}, 128'(ack_edge), 128'(v.exp_edge));
        chk({name, ".rdata"},    128'(rdat),     128'(v.exp_dat));
        chk({name, ".timeout"},  128'(to_cnt),   128'(v.exp_to));
        chk({name, ".stb_cyc"},  128'(stb_cnt),  128'(v.exp_stb));
        chk({name, ".stb_slot"}, 128'(stb_seen), 128'(v.exp_onehot));
        chk({name, ".protocol"}, 128'(bad_cnt),  128'(0));
        if (v.exp_stb != 0) begin
            chk({name, ".m_we"},  128'(c_we),  128'(v.we));
            chk({name, ".m_sel"}, 128'(c_sel), 128'(v.sel));
            chk({name, ".m_adr"}, 128'(c_adr), 128'(v.adr));
            chk({name, ".m_dat"}, 128'(c_dat), 128'(v.wdat));
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".ack"},  128'(bus.wbs_ack_o), 128'(0));
        chk({name, ".dat"},  128'(bus.wbs_dat_o), 128'(0));
        chk({name, ".cyc"},  128'(bus.m_cyc_o),   128'(0));
        chk({name, ".stb"},  128'(bus.m_stb_o),   128'(0));
        chk({name, ".we"},   128'(bus.m_we_o),    128'(0));
        chk({name, ".sel"},  128'(bus.m_sel_o),   128'(0));
        chk({name, ".adr"},  128'(bus.m_adr_o),   128'(0));
        chk({name, ".mdat"}, 128'(bus.m_dat_o),   128'(0));
        chk({name, ".to"},   128'(bus.timeout_o), 128'(0));
    endtask

    initial begin
        vec_t vt[7];
        vec_t v, known;
        int   ack_seen;
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0;
        idle_inputs();

        vt[0] = '{32'h3002_0010, 1'b0, 4'b1111, 32'h0,         3,   4'b0000, 32'h1234_5678, 4,   32'h1234_5678, 0, 3,   4'b0100};
        vt[1] = '{32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_0F0F, 1,   4'b0000, 32'h0BAD_F00D, 2,   32'h0BAD_F00D, 0, 1,   4'b0001};
        vt[2] = '{32'h3001_0000, 1'b0, 4'b1111, 32'h0,         0,   4'b0000, 32'h7777_7777, 256, ERR,           1, 255, 4'b0010};
        vt[3] = '{32'h2000_0000, 1'b0, 4'b1111, 32'h0,         2,   4'b1111, 32'h1111_1111, 1,   ERR,           0, 0,   4'b0000};
        vt[4] = '{32'h3003_FFFC, 1'b0, 4'b1111, 32'h0,         255, 4'b0111, 32'hCAFE_0001, 256, 32'hCAFE_0001, 0, 255, 4'b1000};
        vt[5] = '{32'h3004_0000, 1'b1, 4'b0001, 32'h0000_00FF, 1,   4'b0000, 32'h2222_2222, 1,   ERR,           0, 0,   4'b0000};
        vt[6] = '{32'h3000_0000, 1'b1, 4'b1100, 32'h0102_0304, 2,   4'b1110, 32'h5555_AAAA, 3,   32'h5555_AAAA, 0, 2,   4'b0001};

        #1;
        chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) do_vec($sformatf("vec%0d", i), vt[i]);

        // Slot 3 pending with a foreign slot-0 ack, then async reset mid-transfer.
        bus.wbs_adr_i = 32'h3003_0000; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'b1111;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            bus.m_ack_i = 4'b0001;
            @(posedge clk); #1;
        end
        chk("rst_mid.stb_before", 128'(bus.m_stb_o), 128'(4'b1000));
        chk("rst_mid.ack_before", 128'(bus.wbs_ack_o), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        known = model('{32'h3002_0100, 1'b0, 4'b1111, 32'h0, 2, 4'b0000, 32'h600D_0002, 0, 32'h0, 0, 0, 4'b0000});
        do_vec("after_rst", known);

        // Master abort while slot 1 waits: no ack, data holds the previous response.
        bus.wbs_adr_i = 32'h3001_0008; bus.wbs_we_i = 1'b0; bus.m_ack_i = 4'b0000;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 3; k++) begin @(posedge clk); #1; end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1;
        chk("abort.m_cyc", 128'(bus.m_cyc_o), 128'(0));
        chk("abort.m_stb", 128'(bus.m_stb_o), 128'(0));
        ack_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.wbs_ack_o) ack_seen++;
            @(posedge clk); #1;
        end
        chk("abort.no_ack", 128'(ack_seen), 128'(0));
        chk("abort.dat_hold", 128'(bus.wbs_dat_o), 128'(known.exp_dat));
        do_vec("after_abort", model('{32'h3001_0020, 1'b1, 4'b1010, 32'h0F0F_1234, 1, 4'b0101, 32'h0ACE_0001, 0, 32'h0, 0, 0, 4'b0000}));

        for (int i = 0; i < 24; i++) begin
            int r;
            v.sel = 4'($urandom); v.we = 1'($urandom); v.wdat = $urandom; v.sdat = $urandom;
            v.foreign = 4'($urandom);
            if ($urandom_range(3, 0) != 0) v.adr = {14'h0C00, 2'($urandom), 16'($urandom)};
            else begin
                v.adr = $urandom;
                if ((v.adr >> 18) == (32'h3000_0000 >> 18)) v.adr = v.adr ^ 32'h8000_0000;
            end
            r = $urandom_range(15, 0);
            v.ack_k = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(6, 1);
            do_vec($sformatf("rand%0d", i), model(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
